lut_neuron_loader: RTL
======================

// Module: lut_neuron_loader
// PURPOSE
//   Writable truth-table neuron: the writer side of a fixed LUT neuron ROM. Accepts a
//   streamed truth table (2^IN_BITS entries of OUT_BITS each) over a valid/ready port,
//   stores it, then serves registered lookups. Used to reprogram a sparse-layer neuron
//   at runtime without resynthesis; sits between the config bus and the layer datapath.
// PARAMETERS
//   IN_BITS   8   lookup address width (fan-in x input bit-width)
//   OUT_BITS  2   entry width (neuron output bit-width)
//   WORD_BITS 8   config word width; must be a multiple of OUT_BITS
//   derived: EPW = WORD_BITS/OUT_BITS entries per word (4); NWORDS = 2^IN_BITS/EPW (64)
// PORTS
//   clk        in   1          clock
//   rst        in   1          synchronous, active-high reset
//   cfg_start  in   1          pulse: begin (re)load of the whole table
//   cfg_valid  in   1          cfg_data valid
//   cfg_data   in   WORD_BITS  packed entries; bits [OUT_BITS*i +: OUT_BITS] -> addr EPW*k+i
//   cfg_ready  out  1          loader accepts a word this cycle
//   cfg_done   out  1          table fully loaded (level)
//   M0_valid   in   1          lookup request
//   M0         in   IN_BITS    lookup address (packed neuron inputs, used as binary index)
//   M1_valid   out  1          lookup result valid
//   M1         out  OUT_BITS   table entry at M0
// BEHAVIOUR
//   Reset: state EMPTY, word counter 0, cfg_ready=0, cfg_done=0, M1_valid=0, M1=0.
//     Table contents are not cleared by reset; they are unusable until a reload completes.
//   States: EMPTY -> LOAD on cfg_start; LOAD -> ACTIVE after word NWORDS-1 accepted;
//     ACTIVE -> LOAD on cfg_start. cfg_start in LOAD restarts at word 0 (partial load lost).
//   cfg_ready = 1 exactly in LOAD. Word accepted on cycle with cfg_valid & cfg_ready;
//     word k writes addrs EPW*k .. EPW*k+EPW-1; counter increments by 1 per accept.
//   cfg_start with cfg_valid in same cycle: start wins, data ignored (ready was 0 in
//     EMPTY/ACTIVE; in LOAD counter resets to 0 and that word is dropped).
//   cfg_valid outside LOAD: ignored, no error. cfg_done=1 only in ACTIVE, cleared the
//     cycle after cfg_start is sampled.
//   Lookup: latency 1. In ACTIVE, M0_valid at cycle t -> M1_valid=1, M1=table[M0] at t+1.
//     In EMPTY/LOAD lookups are dropped: M1_valid=0, M1 holds 0.
//   Last-word boundary: lookup issued the cycle the final word is accepted is dropped;
//     first served lookup is the one issued while cfg_done=1.
//   M1 returns 0 whenever M1_valid=0. Counter width log2(NWORDS); no wrap occurs since
//     the FSM leaves LOAD on the last word.
//   Reset mid-load: returns to EMPTY; reload required.
// STRUCTURE
//   Shared package: state enum {EMPTY, LOAD, ACTIVE}, derived EPW/NWORDS helpers,
//   parameter legality check (WORD_BITS % OUT_BITS == 0, 2^IN_BITS % EPW == 0).
//   One sub-module: lut_table_ram (NWORDS x WORD_BITS, 1 write / 1 sync read port,
//   distributed style); read word M0[IN_BITS-1:log2 EPW], select entry with M0 low bits.
// TESTING
//   1 Reset, M0_valid=1 M0=8'h40 -> M1_valid=0, M1=0, cfg_ready=0, cfg_done=0.
//   2 cfg_start, stream 64 words each 8'hE4 -> cfg_done=1; lookup M0=8'h01,8'h02,8'h03
//     -> M1=2'b01,2'b10,2'b11 one cycle later; M0=8'hFC -> 2'b00.
//   3 Load with cfg_valid gaps (random 0-3 idle cycles) -> same table as gap-free load,
//     exactly 64 handshakes counted, cfg_ready drops the cycle after word 63.
//   4 ACTIVE table, cfg_start then 10 words 8'hFF -> cfg_done=0, lookups dropped; second
//     cfg_start + full load of 8'h00 -> every address reads 2'b00.
//   5 rst asserted after 30 words -> EMPTY, cfg_ready=0; lookups dropped until full reload.
//   6 Back-to-back lookups M0=0..255 in ACTIVE -> 256 consecutive M1_valid pulses, each
//     matching the reference model table, 1-cycle latency throughout.

Source files
------------

// File: rtl/lut_neuron_loader_pkg.sv
// Shared types and parameter helpers for the writable LUT neuron.
package lut_neuron_loader_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StLoad,
    StActive
  } state_e;

  // Number of table entries packed into one config word.
  function automatic int unsigned calc_epw(input int unsigned word_bits,
                                           input int unsigned out_bits);
    return word_bits / out_bits;
  endfunction

  // Number of config words needed to fill the whole table.
  function automatic int unsigned calc_nwords(input int unsigned in_bits,
                                              input int unsigned word_bits,
                                              input int unsigned out_bits);
    return (32'd1 << in_bits) / calc_epw(word_bits, out_bits);
  endfunction

  // Words must hold a whole number of entries, and the table must split into at
  // least two whole words so the word counter and entry select stay well formed.
  function automatic bit params_legal(input int unsigned in_bits,
                                      input int unsigned word_bits,
                                      input int unsigned out_bits);
    if (out_bits == 0 || word_bits < out_bits) return 1'b0;
    if ((word_bits % out_bits) != 0) return 1'b0;
    if (((32'd1 << in_bits) % calc_epw(word_bits, out_bits)) != 0) return 1'b0;
    return calc_nwords(in_bits, word_bits, out_bits) >= 2;
  endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Truth-table storage: one write port, one registered read port, no reset on the array.
module lut_table_ram
  import lut_neuron_loader_pkg::*;
#(
  parameter int unsigned Nwords   = 64,
  parameter int unsigned WordBits = 8,
  localparam int unsigned AddrW   = $clog2(Nwords)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [AddrW-1:0]    waddr_i,
  input  logic [WordBits-1:0] wdata_i,
  input  logic                re_i,
  input  logic [AddrW-1:0]    raddr_i,
  output logic [WordBits-1:0] rdata_o
);

  logic [WordBits-1:0] mem_q [Nwords];
  logic [WordBits-1:0] rdata_q;

  // Array write; contents survive reset and are only meaningful after a full load.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Synchronous read, only updated when a lookup is actually being served.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_neuron_loader.sv
// Writable truth-table neuron: streams a table in over a valid/ready port, then serves
// single-cycle-latency registered lookups from it.
module lut_neuron_loader
  import lut_neuron_loader_pkg::*;
#(
  parameter int unsigned InBits   = 8,
  parameter int unsigned OutBits  = 2,
  parameter int unsigned WordBits = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_start_i,
  input  logic                cfg_valid_i,
  input  logic [WordBits-1:0] cfg_data_i,
  output logic                cfg_ready_o,
  output logic                cfg_done_o,
  input  logic                m0_valid_i,
  input  logic [InBits-1:0]   m0_i,
  output logic                m1_valid_o,
  output logic [OutBits-1:0]  m1_o
);

  localparam int unsigned Epw    = calc_epw(WordBits, OutBits);
  localparam int unsigned Nwords = calc_nwords(InBits, WordBits, OutBits);
  localparam int unsigned AddrW  = $clog2(Nwords);
  localparam int unsigned SelW   = (Epw > 1) ? $clog2(Epw) : 1;

  if (!params_legal(InBits, WordBits, OutBits)) begin : g_bad_params
    $error("lut_neuron_loader: WordBits/OutBits/InBits combination is not legal");
  end

  state_e             state_q, state_d;
  logic [AddrW-1:0]   cnt_q, cnt_d;
  logic               wr_en;
  logic               rd_en;
  logic [AddrW-1:0]   rd_addr;
  logic [WordBits-1:0] rd_word;
  logic               valid_q;
  logic [SelW-1:0]    sel_q;

  // State and word counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load sequencing: cfg_start always wins and restarts from word 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (cfg_start_i) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        if (cfg_start_i) begin
          cnt_d = '0;
        end else if (cfg_valid_i) begin
          wr_en = 1'b1;
          if (cnt_q == AddrW'(Nwords - 1)) begin
            state_d = StActive;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StActive: begin
        if (cfg_start_i) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StEmpty;
        cnt_d   = '0;
      end
    endcase
  end

  assign cfg_ready_o = (state_q == StLoad);
  assign cfg_done_o  = (state_q == StActive);

  // Lookups are only served from a completely loaded table.
  assign rd_en   = m0_valid_i && (state_q == StActive);
  assign rd_addr = AddrW'(m0_i / Epw);

  // Lookup pipeline: valid flag and entry-within-word select travel with the read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      sel_q   <= '0;
    end else begin
      valid_q <= rd_en;
      if (rd_en) begin
        sel_q <= SelW'(m0_i % Epw);
      end
    end
  end

  lut_table_ram #(
    .Nwords   (Nwords),
    .WordBits (WordBits)
  ) u_table (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (cnt_q),
    .wdata_i (cfg_data_i),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_word)
  );

  // Result is forced to zero whenever no valid lookup is being returned.
  always_comb begin
    m1_valid_o = valid_q;
    m1_o       = '0;
    if (valid_q) begin
      m1_o = rd_word[int'(sel_q) * OutBits +: OutBits];
    end
  end

endmodule
